mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Memory-access stage fed by the EX/MEM pipeline register; consumes its ALU result, store data and control fields.
//  Performs loads/stores over a req/ack data-memory bus, stalling upstream while a transfer is outstanding.
//  Produces the registered write-back bundle (rd, we, data) consumed by the MEM/WB path.
//  Detects misaligned accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT   256  max cycles waiting for mem_ack before abort (>=2)
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  in_valid       in   1   EX/MEM slot holds a valid instruction
//  sum_out_in     in   32  PC+4 from EX
//  result_in      in   32  ALU result / effective address
//  imm_in         in   32  immediate (LUI)
//  rd_in          in   5   destination register
//  we_in          in   1   register-file write enable
//  controlRF_in   in   2   WB select: 00 ALU, 01 load data, 10 PC+4, 11 imm
//  Type_dm_in     in   3   access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  data2_in       in   32  store data (rs2)
//  store_in       in   1   store instruction
//  stall          out  1   hold EX/MEM and earlier stages (combinational)
//  mem_req        out  1   bus request (registered)
//  mem_we         out  1   1 = write
//  mem_addr       out  32  word-aligned address {result_in[31:2],2'b00}
//  mem_wdata      out  32  lane-replicated store data
//  mem_wstrb      out  4   byte strobes
//  mem_ack        in   1   transfer complete; mem_rdata valid same cycle
//  mem_rdata      in   32  read word
//  wb_valid       out  1   write-back bundle valid
//  wb_rd          out  5   write-back register
//  wb_we          out  1   write-back enable
//  wb_data        out  32  write-back data
//  err_misalign   out  1   1-cycle pulse: misaligned access dropped
//  err_timeout    out  1   1-cycle pulse: transfer aborted on timeout
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, timeout counter 0; all outputs 0 (mem_addr/wdata/wstrb 0).
//  memop = in_valid & (store_in | controlRF_in==01). misalign: H/HU with addr[0]=1, W with addr[1:0]!=0.
//  FSM IDLE:
//   - in_valid & !memop: next edge wb_valid=1, wb_rd=rd_in, wb_we=we_in & (rd_in!=0),
//     wb_data by controlRF_in (00 result, 10 sum_out, 11 imm). Latency 1; stall=0.
//   - memop & misalign: no bus cycle; next edge wb_valid=1, wb_we=0, err_misalign=1; stall=0.
//   - memop & aligned: stall=1; next edge mem_req=1 with addr/we/wdata/wstrb latched, goto BUSY.
//   - !in_valid: wb_valid=0, wb_we=0.
//  FSM BUSY: mem_req and bus fields held stable; counter increments each cycle.
//   - mem_ack: stall=0; next edge mem_req=0, wb_valid=1, goto IDLE.
//     Load: wb_data = lane extract by addr[1:0], sign-extend B/H, zero-extend BU/HU; wb_we=we_in&(rd!=0).
//     Store: wb_we=0.
//   - counter==TIMEOUT-1 & !mem_ack: stall=0; next edge mem_req=0, wb_valid=1, wb_we=0, err_timeout=1, IDLE.
//   - otherwise stall=1; wb_valid=0.
//  mem_ack in IDLE is ignored. Ack and timeout same cycle: ack wins.
//  Store lanes: B wdata={4{d[7:0]}}, wstrb=0001<<addr[1:0]; H wdata={2{d[15:0]}}, wstrb=0011<<addr[1:0]; W 1111.
//  mem_we=0 and mem_wstrb=0000 for loads.
//  Mem op latency: 2 + (cycles from mem_req to mem_ack) edges to wb_valid.
//  Reset mid-transfer: mem_req drops immediately; no write-back issued.
// TESTING
//  ALU op rd=5, result=0x1234, controlRF=00 -> next cycle wb_valid=1, wb_rd=5, wb_we=1, wb_data=0x1234, stall=0.
//  LB addr=0x103, rdata=0x80FF_0000, ack 3 cycles after req -> stall held until ack, wb_data=0xFFFF_FF80.
//  LHU addr=0x102, rdata=0xBEEF_1234, ack at once -> wb_data=0x0000_BEEF; write to rd=0 -> wb_we=0.
//  SB addr=0x201, data2=0xAB -> mem_addr=0x200, wdata=0xABABABAB, wstrb=0010, mem_we=1, wb_we=0.
//  LW addr=0x102 -> no mem_req, err_misalign pulse, wb_we=0; next cycle stall=0.
//  No ack for TIMEOUT cycles -> err_timeout pulse, mem_req=0, IDLE; rst_n low mid-BUSY -> all outputs 0 at once.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Pipeline memory-access stage. Takes the EX/MEM slot, runs
//                loads/stores over a req/ack data bus and produces the
//                registered write-back bundle for the MEM/WB path. While a
//                bus transfer is outstanding the upstream pipe is stalled.
//                Misaligned accesses are dropped and bus transfers that see
//                no acknowledge within TIMEOUT cycles are aborted.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT      cycles in BUSY without mem_ack before abort (>= 2)
//  Ports
//    clk, rst_n         clock (rising edge), async active-low reset
//    in_valid           EX/MEM slot holds a valid instruction
//    sum_out_in         PC+4
//    result_in          ALU result / effective address
//    imm_in             immediate (LUI)
//    rd_in, we_in       destination register and its write enable
//    controlRF_in       WB select: 00 ALU, 01 load, 10 PC+4, 11 imm
//    Type_dm_in         000 B, 001 H, 010 W, 100 BU, 101 HU
//    data2_in, store_in store data and store flag
//    stall              hold upstream stages (combinational)
//    mem_req/we/addr/wdata/wstrb   registered data-memory request
//    mem_ack, mem_rdata            transfer complete / read word
//    wb_valid/rd/we/data           registered write-back bundle
//    err_misalign, err_timeout     single-cycle error pulses
// ============================================================================
module mem_stage #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] sum_out_in,
    input  logic [31:0] result_in,
    input  logic [31:0] imm_in,
    input  logic [4:0]  rd_in,
    input  logic        we_in,
    input  logic [1:0]  controlRF_in,
    input  logic [2:0]  Type_dm_in,
    input  logic [31:0] data2_in,
    input  logic        store_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic [31:0] wb_data,
    output logic        err_misalign,
    output logic        err_timeout
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;

    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_we_q, wb_we_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              err_misalign_q, err_misalign_d;
    logic              err_timeout_q, err_timeout_d;

    // Attributes of the outstanding transfer, needed once the ack arrives.
    logic [4:0]        op_rd_q, op_rd_d;
    logic              op_we_q, op_we_d;
    logic              op_store_q, op_store_d;
    logic [2:0]        op_type_q, op_type_d;
    logic [1:0]        op_off_q, op_off_d;

    logic              w_memop;
    logic              w_is_byte;
    logic              w_is_half;
    logic              w_misalign;
    logic [1:0]        w_off;
    logic [31:0]       w_st_wdata;
    logic [3:0]        w_st_wstrb;
    logic [31:0]       w_alu_data;
    logic [31:0]       w_rd_shift;
    logic [31:0]       w_load_data;
    logic              w_timeout;
    logic              w_stall;

    // ------------------------------------------------------------------
    // Decode of the incoming slot
    // ------------------------------------------------------------------
    assign w_memop    = in_valid & (store_in | (controlRF_in == 2'b01));
    assign w_off      = result_in[1:0];
    assign w_is_byte  = (Type_dm_in[1:0] == 2'b00);
    assign w_is_half  = (Type_dm_in[1:0] == 2'b01);
    // Anything that is neither byte nor half is treated as a word access.
    assign w_misalign = (w_is_half & w_off[0]) |
                        (~w_is_byte & ~w_is_half & (w_off != 2'b00));

    always_comb begin
        w_st_wdata = data2_in;
        w_st_wstrb = 4'b1111;
        if (w_is_byte) begin
            w_st_wdata = {4{data2_in[7:0]}};
            w_st_wstrb = 4'b0001 << w_off;
        end else if (w_is_half) begin
            w_st_wdata = {2{data2_in[15:0]}};
            w_st_wstrb = 4'b0011 << w_off;
        end
    end

    always_comb begin
        case (controlRF_in)
            2'b10:   w_alu_data = sum_out_in;
            2'b11:   w_alu_data = imm_in;
            default: w_alu_data = result_in;
        endcase
    end

    // Load lane extraction: shift the addressed byte/half down to bit 0,
    // then sign- or zero-extend depending on the U flag (Type_dm[2]).
    assign w_rd_shift = mem_rdata >> {op_off_q, 3'b000};

    always_comb begin
        case (op_type_q[1:0])
            2'b00:   w_load_data = op_type_q[2] ? {24'd0, w_rd_shift[7:0]}
                                                : {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
            2'b01:   w_load_data = op_type_q[2] ? {16'd0, w_rd_shift[15:0]}
                                                : {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
            default: w_load_data = mem_rdata;
        endcase
    end

    assign w_timeout = (cnt_q == c_cnt_last);

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wstrb_d    = mem_wstrb_q;
        wb_valid_d     = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_we_d        = 1'b0;
        wb_data_d      = wb_data_q;
        err_misalign_d = 1'b0;
        err_timeout_d  = 1'b0;
        op_rd_d        = op_rd_q;
        op_we_d        = op_we_q;
        op_store_d     = op_store_q;
        op_type_d      = op_type_q;
        op_off_d       = op_off_q;
        w_stall        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid && !w_memop) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_in;
                    wb_we_d    = we_in & (rd_in != 5'd0);
                    wb_data_d  = w_alu_data;
                end else if (w_memop && w_misalign) begin
                    wb_valid_d     = 1'b1;
                    wb_rd_d        = rd_in;
                    wb_data_d      = 32'd0;
                    err_misalign_d = 1'b1;
                end else if (w_memop) begin
                    w_stall     = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = store_in;
                    mem_addr_d  = {result_in[31:2], 2'b00};
                    mem_wdata_d = store_in ? w_st_wdata : 32'd0;
                    mem_wstrb_d = store_in ? w_st_wstrb : 4'b0000;
                    op_rd_d     = rd_in;
                    op_we_d     = we_in;
                    op_store_d  = store_in;
                    op_type_d   = Type_dm_in;
                    op_off_d    = w_off;
                    cnt_d       = '0;
                    state_d     = S_BUSY;
                end
            end

            S_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ack has priority over a coincident timeout.
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = op_rd_q;
                    if (op_store_q) begin
                        wb_we_d   = 1'b0;
                        wb_data_d = 32'd0;
                    end else begin
                        wb_we_d   = op_we_q & (op_rd_q != 5'd0);
                        wb_data_d = w_load_data;
                    end
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (w_timeout) begin
                    mem_req_d     = 1'b0;
                    wb_valid_d    = 1'b1;
                    wb_rd_d       = op_rd_q;
                    wb_data_d     = 32'd0;
                    err_timeout_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 32'd0;
            mem_wdata_q    <= 32'd0;
            mem_wstrb_q    <= 4'b0000;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_we_q        <= 1'b0;
            wb_data_q      <= 32'd0;
            err_misalign_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            op_rd_q        <= 5'd0;
            op_we_q        <= 1'b0;
            op_store_q     <= 1'b0;
            op_type_q      <= 3'b000;
            op_off_q       <= 2'b00;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wstrb_q    <= mem_wstrb_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_we_q        <= wb_we_d;
            wb_data_q      <= wb_data_d;
            err_misalign_q <= err_misalign_d;
            err_timeout_q  <= err_timeout_d;
            op_rd_q        <= op_rd_d;
            op_we_q        <= op_we_d;
            op_store_q     <= op_store_d;
            op_type_q      <= op_type_d;
            op_off_q       <= op_off_d;
        end
    end

    // Stall is forced low while reset is asserted so every output reads 0.
    assign stall        = w_stall & rst_n;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wstrb    = mem_wstrb_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_we        = wb_we_q;
    assign wb_data      = wb_data_q;
    assign err_misalign = err_misalign_q;
    assign err_timeout  = err_timeout_q;

endmodule
`default_nettype wire
